mult_product_accumulator: RTL
=============================

# mult_product_accumulator

Sequential consumer placed directly downstream of the 8x8 `array_multiplier`. It takes the multiplier's 16-bit product through a valid/ready handshake and sums a fixed number of consecutive products into one wider accumulator word. It then presents the result through a second valid/ready handshake. The multiplier plus this block form a dot-product / MAC datapath.

## Interface

Parameters:
- `N_TERMS`, 4: products summed per frame; legal range 1..16.
- `ACC_W`, 20: accumulator width; legal range 16..32; results wrap modulo 2^ACC_W.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `prod_i`  in  16  unsigned product, connected to multiplier `sum`.
- `prod_valid_i`  in  1  `prod_i` is valid this cycle.
- `prod_ready_o`  out  1  block accepts a product this cycle.
- `clear_i`  in  1  synchronous frame abort.
- `acc_o`  out  ACC_W  accumulated sum; meaningful while `acc_valid_o`=1.
- `acc_valid_o`  out  1  frame result available.
- `acc_ready_i`  in  1  downstream takes result.
- `count_o`  out  5  products accepted in current frame.
- `ovf_o`  out  1  sticky per frame: a carry out of bit ACC_W-1 occurred.

## Operation

- FSM states: IDLE, ACCUM, DONE.
- Product accept event: `prod_valid_i` & `prod_ready_o` at a rising edge.
- `prod_ready_o` = 1 in IDLE and ACCUM, 0 in DONE. It is decoded from the state register only, with no combinational path from any input.
- `acc_valid_o` = 1 only in DONE.
- IDLE + accept:
  - `acc` <= zero-extended `prod_i`; `count` <= 1; `ovf` <= 0.
  - Next state is DONE if `N_TERMS`=1, else ACCUM.
- ACCUM + accept:
  - `acc` <= (`acc` + `prod_i`) mod 2^ACC_W; `count` <= `count`+1.
  - `ovf` <= `ovf` | carry-out.
  - Next state is DONE when the new count equals `N_TERMS`.
- ACCUM without accept: all state holds. Gaps in `prod_valid_i` are legal.
- DONE: `acc_o`, `count_o` and `ovf_o` are held stable.
- DONE + `acc_ready_i`=1: next state IDLE; `count` <= 0. `acc` and `ovf` keep their values until the next accept.
- `clear_i`=1 in any state has priority over every other event:
  - Next state IDLE; `acc`, `count` and `ovf` <= 0.
  - A product presented in that same cycle is discarded, even though `prod_ready_o` was 1.
- Arithmetic is unsigned. The adder is ACC_W+1 bits wide; its MSB is the carry-out.
- With ACC_W >= 16+ceil(log2(N_TERMS)), overflow is impossible and `ovf_o` stays 0.

## Timing

- Reset (`rst_n`=0, asynchronous): state IDLE, `acc_o`=0, `count_o`=0, `ovf_o`=0, `acc_valid_o`=0, `prod_ready_o`=1 once the state is IDLE.
- Reset asserted mid-frame aborts the frame immediately, without waiting for a clock edge.
- All outputs are registered or state-decoded; none depend combinationally on inputs.
- Latency: `acc_valid_o` rises in the cycle after the edge that accepts the N_TERMS-th product.
- Best-case throughput: one frame per N_TERMS+1 cycles. This is N accept cycles plus one DONE cycle with `acc_ready_i` held high.
- `acc_valid_o` falls, and `prod_ready_o` rises, in the cycle after the result handshake edge. A new product can be accepted in that same cycle.
- Backpressure: while DONE and `acc_ready_i`=0, the block stays in DONE indefinitely with `prod_ready_o`=0. Upstream must hold its product.
- Simultaneous `clear_i` and `acc_ready_i` in DONE: the clear wins; outputs become 0 next cycle.

## Test plan

- Default parameters. Feed the multiplier outputs for 9x8, 32x32, 0xDA x 0xAD and 0xBE x 0xEF, i.e. 72, 1024, 37714, 45410, on back-to-back cycles with `acc_ready_i`=1. Required: `acc_o`=84220 (0x148FC), `ovf_o`=0, `count_o`=4, `acc_valid_o` high for exactly one cycle, one cycle after the fourth accept.
- Same stimulus with `prod_valid_i` low for 3 cycles between the 2nd and 3rd products. Required: identical result 0x148FC; `count_o` holds 2 during the gap.
- `ACC_W`=16, `N_TERMS`=2, products 37714 then 45410. Required: `acc_o`=17588, `ovf_o`=1. The next frame of 1+1 gives `acc_o`=2, `ovf_o`=0.
- Default parameters: complete a frame, then hold `acc_ready_i`=0 for 5 cycles while `prod_valid_i`=1 with value 100. Required: `acc_o` stable at 84220, `prod_ready_o`=0 throughout, and no product consumed until one cycle after `acc_ready_i` rises.
- Abort mid-frame: accept 72 and 1024, then pulse `clear_i` in the same cycle as `prod_valid_i`=1 with value 500. Required: `acc_o`=0 and `count_o`=0 next cycle, and 500 is dropped. Repeat the frame using an asynchronous `rst_n` pulse between clock edges instead of `clear_i`; required: all outputs are 0 before the next edge.
- `N_TERMS`=1: products 72 then 1024 with `acc_ready_i`=1. Required: two results, 72 then 1024, each one cycle after its accept; `prod_ready_o` low for one cycle between them.

Source files
------------

// File: rtl/mult_product_accumulator.sv
// mult_product_accumulator: sums N_TERMS consecutive 16-bit products from the
// upstream multiplier into an ACC_W-bit word and hands the result downstream
// over a valid/ready handshake. A sticky flag records any carry out of the
// accumulator MSB within the current frame.
module mult_product_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      prod_i,
  input  logic             prod_valid_i,
  output logic             prod_ready_o,
  input  logic             clear_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic [4:0]       count_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         SUM_W      = ACC_W + 1;
  localparam logic [4:0] LAST_COUNT = 5'(N_TERMS);

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [4:0]       count;
  logic             ovf;
  logic             accept;
  logic [SUM_W-1:0] sum_wide;
  logic [4:0]       count_inc;

  // Unsigned add one bit wider than the accumulator; the MSB is the carry-out.
  function automatic logic [SUM_W-1:0] add_wide(input logic [ACC_W-1:0] a,
                                                input logic [15:0]      b);
    return SUM_W'(a) + SUM_W'(b);
  endfunction

  // Handshake outputs decode the state register only, so no input reaches them.
  assign prod_ready_o = (state != DONE);
  assign acc_valid_o  = (state == DONE);
  assign acc_o        = acc;
  assign count_o      = count;
  assign ovf_o        = ovf;

  assign accept    = prod_valid_i & prod_ready_o;
  assign sum_wide  = add_wide(acc, prod_i);
  assign count_inc = count + 5'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; clear overrides every other event.
  always_comb begin
    state_next = state;
    if (clear_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_next = (N_TERMS == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept && (count_inc == LAST_COUNT)) begin
            state_next = DONE;
          end
        end
        DONE: begin
          if (acc_ready_i) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Accumulator, term counter and sticky overflow; acc/ovf survive the result
  // handshake and are only replaced by the first product of the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (clear_i) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc   <= ACC_W'(prod_i);
            count <= 5'd1;
            ovf   <= 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc   <= sum_wide[ACC_W-1:0];
            count <= count_inc;
            ovf   <= ovf | sum_wide[ACC_W];
          end
        end
        DONE: begin
          if (acc_ready_i) begin
            count <= '0;
          end
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

endmodule
